// File: rtl/dec38_seq_if.sv
// Bus between dec38_seq and its driver: control/code in, one-hot decode and status out.
interface dec38_seq_if;
    logic       en;
    logic       load;
    logic       scan;
    logic [2:0] C;
    logic [0:7] D;
    logic [2:0] code_q;
    logic       valid;
    logic       wrap;

    modport master (output en, load, scan, C, input D, code_q, valid, wrap);
    modport slave  (input en, load, scan, C, output D, code_q, valid, wrap);
endinterface

// File: rtl/dec38_seq.sv
// Registered 3-to-8 one-hot decoder with a code hold register and a divided auto-scan
// that walks a single one across D[0]..D[7].
module dec38_seq #(
    parameter int unsigned SCAN_DIV = 1,
    parameter int unsigned DIV_W    = 8
) (
    input logic         clk,
    input logic         rst,
    dec38_seq_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_SCAN = 2'd2;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [1:0]       state_q, state_d;
    logic [2:0]       code_q,  code_d;
    logic [DIV_W-1:0] div_q,   div_d;
    logic [0:7]       d_q,     d_d;
    logic             wrap_q,  wrap_d;

    function automatic logic [0:7] onehot(input logic [2:0] k);
        logic [0:7] r;
        r    = '0;
        r[k] = 1'b1;
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        div_d   = div_q;
        wrap_d  = 1'b0;
        if (!bus.en) begin
            state_d = ST_IDLE;
            div_d   = '0;
        end else if (bus.load) begin
            // A load wins over a scan advance landing in the same cycle.
            code_d  = bus.C;
            div_d   = '0;
            state_d = bus.scan ? ST_SCAN : ST_HOLD;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (bus.scan) begin
                        state_d = ST_SCAN;
                        div_d   = '0;
                    end
                end
                ST_SCAN: begin
                    if (!bus.scan) begin
                        state_d = ST_HOLD;
                        div_d   = '0;
                    end else if (div_q == DIV_LAST) begin
                        code_d = code_q + 3'd1;
                        div_d  = '0;
                        wrap_d = (code_q == 3'd7);
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        // D is decoded from the next code so it lines up with code_q after the edge.
        d_d = (state_d != ST_IDLE) ? onehot(code_d) : 8'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            div_q   <= '0;
            d_q     <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            div_q   <= div_d;
            d_q     <= d_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.D      = d_q;
    assign bus.code_q = code_q;
    assign bus.valid  = (state_q != ST_IDLE);
    assign bus.wrap   = wrap_q;

endmodule

// File: tb/tb_dec38_seq.sv
// Directed bench for dec38_seq: SCAN_DIV=1 and SCAN_DIV=3 instances, expected outputs
// queued when each step is driven and compared one cycle later.
module tb_dec38_seq;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    dec38_seq_if bus_a ();
    dec38_seq_if bus_b ();

    dec38_seq #(.SCAN_DIV(1), .DIV_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    dec38_seq #(.SCAN_DIV(3), .DIV_W(8)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    typedef struct {
        int         sel;
        logic [0:7] d;
        logic [2:0] code;
        logic       valid;
        logic       wrap;
        string      tag;
    } exp_t;

    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [0:7] oh(input int k);
        logic [0:7] r;
        r = 8'b10000000;
        return r >> k;
    endfunction

    // Reference 8-to-3 encoder used to re-encode the decoder output.
    function automatic logic [2:0] enc(input logic [0:7] d);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++)
            if (d[i]) r = 3'(i);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic r, input logic e, input logic l,
                         input logic s, input logic [2:0] c);
        rst = r;
        bus_a.en = (sel == 0) ? e : 1'b0;
        bus_a.load = (sel == 0) ? l : 1'b0;
        bus_a.scan = (sel == 0) ? s : 1'b0;
        bus_a.C = (sel == 0) ? c : 3'd0;
        bus_b.en = (sel == 1) ? e : 1'b0;
        bus_b.load = (sel == 1) ? l : 1'b0;
        bus_b.scan = (sel == 1) ? s : 1'b0;
        bus_b.C = (sel == 1) ? c : 3'd0;
    endtask

    task automatic expect_out(input int sel, input logic [0:7] d, input logic [2:0] code,
                              input logic v, input logic w, input string tag);
        exp_t x;
        x.sel = sel; x.d = d; x.code = code; x.valid = v; x.wrap = w; x.tag = tag;
        sb.push_back(x);
    endtask

    task automatic check_one(input exp_t x);
        logic [0:7] d;
        logic [2:0] code;
        logic       v, w;
        if (x.sel == 0) begin
            d = bus_a.D; code = bus_a.code_q; v = bus_a.valid; w = bus_a.wrap;
        end else begin
            d = bus_b.D; code = bus_b.code_q; v = bus_b.valid; w = bus_b.wrap;
        end
        chk({x.tag, ".D"}, 32'(d), 32'(x.d));
        chk({x.tag, ".code_q"}, 32'(code), 32'(x.code));
        chk({x.tag, ".valid"}, 32'(v), 32'(x.valid));
        chk({x.tag, ".wrap"}, 32'(w), 32'(x.wrap));
        chk({x.tag, ".ones"}, 32'($countones(d)), x.valid ? 32'd1 : 32'd0);
        if (x.valid) chk({x.tag, ".reenc"}, 32'(enc(d)), 32'(x.code));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        while (sb.size() > 0) check_one(sb.pop_front());
    endtask

    task automatic step(input int sel, input logic r, input logic e, input logic l,
                        input logic s, input logic [2:0] c, input logic [0:7] d,
                        input logic [2:0] code, input logic v, input logic w,
                        input string tag);
        drive(sel, r, e, l, s, c);
        expect_out(sel, d, code, v, w, tag);
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        @(posedge clk);
        #1;
        expect_out(0, 8'b0, 3'd0, 1'b0, 1'b0, "reset_a");
        expect_out(1, 8'b0, 3'd0, 1'b0, 1'b0, "reset_b");
        tick();

        // Load code 0, then hold.
        step(0, 0, 1, 1, 0, 3'd0, 8'b10000000, 3'd0, 1, 0, "load0");
        step(0, 0, 1, 0, 0, 3'd0, 8'b10000000, 3'd0, 1, 0, "hold0_a");
        step(0, 0, 1, 0, 0, 3'd5, 8'b10000000, 3'd0, 1, 0, "hold0_b");

        // Static decode of every code on consecutive cycles.
        for (int k = 0; k < 8; k++)
            step(0, 0, 1, 1, 0, 3'(k), oh(k), 3'(k), 1, 0, $sformatf("static%0d", k));

        // SCAN_DIV=1 scan through the wrap.
        step(0, 0, 1, 1, 1, 3'd6, 8'b00000010, 3'd6, 1, 0, "scan1_ld6");
        step(0, 0, 1, 0, 1, 3'd0, 8'b00000001, 3'd7, 1, 0, "scan1_7");
        step(0, 0, 1, 0, 1, 3'd0, 8'b10000000, 3'd0, 1, 1, "scan1_wrap");
        step(0, 0, 1, 0, 1, 3'd0, 8'b01000000, 3'd1, 1, 0, "scan1_1");
        step(0, 0, 1, 0, 1, 3'd0, 8'b00100000, 3'd2, 1, 0, "scan1_2");
        step(0, 0, 1, 0, 1, 3'd0, 8'b00010000, 3'd3, 1, 0, "scan1_3");

        // Load colliding with a scan advance.
        step(0, 0, 1, 1, 1, 3'd1, 8'b01000000, 3'd1, 1, 0, "ld_over_adv");

        // Disable, then en without load stays idle.
        step(0, 0, 0, 0, 1, 3'd0, 8'b0, 3'd1, 0, 0, "en0");
        step(0, 0, 1, 0, 1, 3'd4, 8'b0, 3'd1, 0, 0, "idle_noload_s");
        step(0, 0, 1, 0, 0, 3'd4, 8'b0, 3'd1, 0, 0, "idle_noload");

        // HOLD -> SCAN gives no advance on the entry cycle; SCAN -> HOLD freezes.
        step(0, 0, 1, 1, 0, 3'd2, 8'b00100000, 3'd2, 1, 0, "hold_ld2");
        step(0, 0, 1, 0, 1, 3'd0, 8'b00100000, 3'd2, 1, 0, "hold_to_scan");
        step(0, 0, 1, 0, 1, 3'd0, 8'b00010000, 3'd3, 1, 0, "scan_first_adv");
        step(0, 0, 1, 0, 0, 3'd0, 8'b00010000, 3'd3, 1, 0, "scan_to_hold");
        step(0, 0, 1, 0, 0, 3'd0, 8'b00010000, 3'd3, 1, 0, "hold_frozen");

        // Reset mid-scan at code 5, then restart from 7.
        step(0, 0, 1, 1, 1, 3'd4, 8'b00001000, 3'd4, 1, 0, "pre_rst4");
        step(0, 0, 1, 0, 1, 3'd0, 8'b00000100, 3'd5, 1, 0, "pre_rst5");
        step(0, 1, 1, 0, 1, 3'd0, 8'b0, 3'd0, 0, 0, "rst_mid_scan");
        step(0, 0, 1, 1, 1, 3'd7, 8'b00000001, 3'd7, 1, 0, "restart7");
        step(0, 0, 1, 0, 1, 3'd0, 8'b10000000, 3'd0, 1, 1, "restart_wrap");
        step(0, 0, 1, 0, 1, 3'd0, 8'b01000000, 3'd1, 1, 0, "restart_1");
        step(0, 0, 0, 0, 0, 3'd0, 8'b0, 3'd1, 0, 0, "a_off");

        // SCAN_DIV=3: each code held for 3 cycles; wrap 24 cycles after load.
        step(1, 0, 1, 1, 1, 3'd0, 8'b10000000, 3'd0, 1, 0, "div3_ld0");
        for (int i = 1; i <= 36; i++)
            step(1, 0, 1, 0, 1, 3'd0, oh((i / 3) % 8), 3'((i / 3) % 8), 1,
                 (i == 24), $sformatf("div3_c%0d", i));
        step(1, 0, 1, 0, 0, 3'd0, 8'b00001000, 3'd4, 1, 0, "div3_freeze");
        step(1, 0, 1, 0, 0, 3'd0, 8'b00001000, 3'd4, 1, 0, "div3_frozen");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
